// File: rtl/catch_scorer_pkg.sv
// Shared game constants and state encoding for the catch scorer.
package catch_scorer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int          CATCH_Y_DEF    = 320;
  localparam int          LIVES_INIT_DEF = 3;
  localparam logic [15:0] BCD_MAX        = 16'h9999;

endpackage

// File: rtl/catch_scorer_bcd_add_sat.sv
// Adds a small binary count to a 4-digit BCD value, clamping at 9999.
module bcd_add_sat
  import catch_scorer_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic [15:0]   bcd_in,
  input  logic [CW-1:0] add,
  output logic [15:0]   bcd_out
);

  logic [15:0] sum;
  logic [4:0]  carry;
  logic [4:0]  dsum;

  // Ripple one decimal digit at a time. The addend is at most 9, so a digit
  // sum never exceeds 18 and each digit carries at most 1 onward.
  always_comb begin
    sum   = '0;
    dsum  = '0;
    carry = 5'(add);
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, bcd_in[4*i +: 4]} + carry;
      if (dsum >= 5'd10) begin
        sum[4*i +: 4] = 4'(dsum - 5'd10);
        carry         = 5'd1;
      end else begin
        sum[4*i +: 4] = dsum[3:0];
        carry         = 5'd0;
      end
    end
    bcd_out = (carry != 5'd0) ? BCD_MAX : sum;
  end

endmodule

// File: rtl/catch_scorer.sv
// Per-tick catch evaluation: scores vegetables, takes lives on bugs, and runs
// the IDLE/PLAY/HIT/OVER game flow.
module catch_scorer
  import catch_scorer_pkg::*;
#(
  parameter int NUM_OBJ    = 4,
  parameter int CATCH_Y    = CATCH_Y_DEF,
  parameter int LIVES_INIT = LIVES_INIT_DEF,
  parameter int HIT_TICKS  = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic [2:0]           farmer_x,
  input  logic [NUM_OBJ-1:0]   obj_valid,
  input  logic [3*NUM_OBJ-1:0] obj_lane,
  input  logic [10*NUM_OBJ-1:0] obj_y,
  input  logic [NUM_OBJ-1:0]   obj_is_bug,
  output logic [15:0]          score_bcd,
  output logic [1:0]           lives,
  output logic [1:0]           state,
  output logic                 hit_flash,
  output logic                 catch_pulse,
  output logic                 bug_pulse
);

  localparam int CW = $clog2(NUM_OBJ + 1);
  localparam int HW = $clog2(HIT_TICKS + 1);

  state_t        state_q, state_d;
  logic [15:0]   score_q, score_d, score_sum;
  logic [1:0]    lives_q, lives_d;
  logic [HW-1:0] hit_q, hit_d;
  logic          catch_d, bug_d;

  logic [NUM_OBJ-1:0] elig, veg_hit;
  logic               bug_any;
  logic [CW-1:0]      veg_cnt;

  // A slot is in the catch window when shown, at the catch row and in the farmer's lane.
  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
    assign elig[g] = obj_valid[g]
                   && (obj_y[10*g +: 10] == 10'(CATCH_Y))
                   && (obj_lane[3*g +: 3] == farmer_x);
  end

  assign veg_hit = elig & ~obj_is_bug;
  assign bug_any = |(elig & obj_is_bug);

  // Count caught vegetables this tick.
  always_comb begin
    veg_cnt = '0;
    for (int i = 0; i < NUM_OBJ; i++) veg_cnt = veg_cnt + CW'(veg_hit[i]);
  end

  bcd_add_sat #(.CW(CW)) u_add (
    .bcd_in  (score_q),
    .add     (veg_cnt),
    .bcd_out (score_sum)
  );

  // Next-state and next-value logic for the game flow.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    hit_d   = hit_q;
    catch_d = 1'b0;
    bug_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // start wins over a coincident tick; that tick is never evaluated
        if (start) begin
          state_d = ST_PLAY;
          score_d = '0;
          lives_d = 2'(LIVES_INIT);
          hit_d   = '0;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          score_d = score_sum;
          catch_d = (veg_cnt != '0);
          if (bug_any) begin
            bug_d = 1'b1;
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = ST_HIT;
              hit_d   = '0;
            end
          end
        end
      end
      ST_HIT: begin
        // bugs are ignored while invincible; vegetables still score
        if (tick) begin
          score_d = score_sum;
          catch_d = (veg_cnt != '0);
          if (hit_q == HW'(HIT_TICKS - 1)) begin
            state_d = ST_PLAY;
            hit_d   = '0;
          end else begin
            hit_d = hit_q + HW'(1);
          end
        end
      end
      ST_OVER: begin
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Game registers; reset aborts any in-flight evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      lives_q     <= 2'(LIVES_INIT);
      hit_q       <= '0;
      catch_pulse <= 1'b0;
      bug_pulse   <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      catch_pulse <= catch_d;
      bug_pulse   <= bug_d;
    end
  end

  assign score_bcd = score_q;
  assign lives     = lives_q;
  assign state     = state_q;
  assign hit_flash = (state_q == ST_HIT);

endmodule

// File: tb/tb_catch_scorer.sv
// Randomized and directed bench for catch_scorer against a decimal game model.
module tb_catch_scorer;

  logic        clk, rst, tick, start;
  logic [2:0]  farmer_x;
  logic [3:0]  obj_valid, obj_is_bug;
  logic [11:0] obj_lane;
  logic [39:0] obj_y;
  logic [15:0] score_bcd;
  logic [1:0]  lives, state;
  logic        hit_flash, catch_pulse, bug_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: plain decimal score, lives, state number, ticks spent in HIT
  int m_score, m_lives, m_state, m_hit;
  bit m_catch, m_bug;

  catch_scorer dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .farmer_x(farmer_x),
    .obj_valid(obj_valid), .obj_lane(obj_lane), .obj_y(obj_y), .obj_is_bug(obj_is_bug),
    .score_bcd(score_bcd), .lives(lives), .state(state), .hit_flash(hit_flash),
    .catch_pulse(catch_pulse), .bug_pulse(bug_pulse)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_score = 0; m_lives = 3; m_state = 0; m_hit = 0; m_catch = 0; m_bug = 0;
  endtask

  task automatic model_step(input bit t, input bit s);
    int veg = 0;
    bit bug = 0;
    int st = m_state;
    for (int i = 0; i < 4; i++)
      if (obj_valid[i] && obj_y[10*i +: 10] == 10'd320 && obj_lane[3*i +: 3] == farmer_x) begin
        if (obj_is_bug[i]) bug = 1; else veg++;
      end
    m_catch = 0; m_bug = 0;
    if (st == 0) begin
      if (s) begin m_state = 1; m_score = 0; m_lives = 3; m_hit = 0; end
    end else if (st == 3) begin
      if (s) m_state = 0;
    end else if (t) begin
      m_score = (m_score + veg > 9999) ? 9999 : m_score + veg;
      m_catch = (veg > 0);
      if (st == 1 && bug) begin
        m_bug = 1;
        m_lives--;
        if (m_lives == 0) m_state = 3;
        else begin m_state = 2; m_hit = 0; end
      end else if (st == 2) begin
        m_hit++;
        if (m_hit == 60) m_state = 1;
      end
    end
  endtask

  task automatic clear_slots();
    obj_valid = '0; obj_is_bug = '0; obj_lane = '0; obj_y = '0;
  endtask

  task automatic set_slot(input int i, input bit v, input logic [2:0] ln, input logic [9:0] y, input bit b);
    obj_valid[i] = v; obj_lane[3*i +: 3] = ln; obj_y[10*i +: 10] = y; obj_is_bug[i] = b;
  endtask

  task automatic cycle(input bit t, input bit s);
    tick = t; start = s;
    model_step(t, s);
    @(posedge clk); #1;
    tick = 0; start = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick = 0; start = 0; clear_slots();
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_tests++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_score got %h want 0000", score_bcd); end
    n_tests++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives got %0d want 3", lives); end
    n_tests++; if ({hit_flash, catch_pulse, bug_pulse} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {hit_flash, catch_pulse, bug_pulse}); end
    // tick in IDLE is not evaluated
    farmer_x = 3'd2; set_slot(0, 1, 3'd2, 10'd320, 0);
    cycle(1, 0);
    n_tests++; if (score_bcd !== 16'h0000 || catch_pulse !== 1'b0) begin n_fail++; $display("FAIL idle_tick got score %h catch %b want 0000 0", score_bcd, catch_pulse); end
  endtask

  task automatic test_first_catch();
    do_reset();
    cycle(0, 1);
    n_tests++; if (state !== 2'd1 || lives !== 2'd3) begin n_fail++; $display("FAIL start_play got st %0d lives %0d want 1 3", state, lives); end
    farmer_x = 3'd2; set_slot(0, 1, 3'd2, 10'd320, 0);
    cycle(1, 0);
    n_tests++; if (score_bcd !== 16'h0001) begin n_fail++; $display("FAIL first_score got %h want 0001", score_bcd); end
    n_tests++; if (catch_pulse !== 1'b1) begin n_fail++; $display("FAIL first_catch got %b want 1", catch_pulse); end
    cycle(0, 0);
    n_tests++; if (catch_pulse !== 1'b0 || score_bcd !== 16'h0001) begin n_fail++; $display("FAIL catch_once got catch %b score %h want 0 0001", catch_pulse, score_bcd); end
  endtask

  task automatic test_bcd_carry();
    int rem;
    do_reset();
    cycle(0, 1);
    farmer_x = 3'd5;
    for (int i = 0; i < 4; i++) set_slot(i, 1, 3'd5, 10'd320, 0);
    for (int k = 0; k < 24; k++) cycle(1, 0);
    obj_valid = 4'b0111;
    cycle(1, 0);
    n_tests++; if (score_bcd !== 16'h0099) begin n_fail++; $display("FAIL bcd_99 got %h want 0099", score_bcd); end
    obj_valid = 4'b0011;
    cycle(1, 0);
    n_tests++; if (score_bcd !== 16'h0101) begin n_fail++; $display("FAIL bcd_carry got %h want 0101", score_bcd); end
    obj_valid = 4'b1111;
    while (m_score + 4 <= 9998) cycle(1, 0);
    rem = 9998 - m_score;
    if (rem > 0) begin obj_valid = 4'((1 << rem) - 1); cycle(1, 0); end
    n_tests++; if (score_bcd !== 16'h9998) begin n_fail++; $display("FAIL bcd_9998 got %h want 9998", score_bcd); end
    obj_valid = 4'b0011;
    cycle(1, 0);
    n_tests++; if (score_bcd !== 16'h9999) begin n_fail++; $display("FAIL bcd_sat got %h want 9999", score_bcd); end
    obj_valid = 4'b1111;
    cycle(1, 0);
    n_tests++; if (score_bcd !== 16'h9999 || catch_pulse !== 1'b1) begin n_fail++; $display("FAIL bcd_hold got %h catch %b want 9999 1", score_bcd, catch_pulse); end
  endtask

  task automatic test_bugs_hit();
    do_reset();
    cycle(0, 1);
    farmer_x = 3'd1;
    set_slot(0, 1, 3'd1, 10'd320, 1); set_slot(1, 1, 3'd1, 10'd320, 1);
    cycle(1, 0);
    n_tests++; if (lives !== 2'd2 || state !== 2'd2 || hit_flash !== 1'b1) begin n_fail++; $display("FAIL two_bugs got lives %0d st %0d flash %b want 2 2 1", lives, state, hit_flash); end
    n_tests++; if (bug_pulse !== 1'b1) begin n_fail++; $display("FAIL bug_pulse got %b want 1", bug_pulse); end
    cycle(0, 0);
    n_tests++; if (bug_pulse !== 1'b0) begin n_fail++; $display("FAIL bug_once got %b want 0", bug_pulse); end
    cycle(1, 0);
    n_tests++; if (lives !== 2'd2 || bug_pulse !== 1'b0) begin n_fail++; $display("FAIL hit_ignore got lives %0d bug %b want 2 0", lives, bug_pulse); end
    clear_slots(); set_slot(0, 1, 3'd1, 10'd320, 0);
    cycle(1, 0);
    n_tests++; if (score_bcd !== 16'h0001 || state !== 2'd2) begin n_fail++; $display("FAIL hit_score got %h st %0d want 0001 2", score_bcd, state); end
    clear_slots();
    for (int k = 0; k < 57; k++) cycle(1, 0);
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL hit_59 got st %0d want 2", state); end
    cycle(1, 0);
    n_tests++; if (state !== 2'd1 || hit_flash !== 1'b0) begin n_fail++; $display("FAIL hit_60 got st %0d flash %b want 1 0", state, hit_flash); end
  endtask

  task automatic test_game_over();
    do_reset();
    cycle(0, 1);
    farmer_x = 3'd6;
    for (int r = 0; r < 2; r++) begin
      clear_slots(); set_slot(2, 1, 3'd6, 10'd320, 1);
      cycle(1, 0);
      clear_slots();
      for (int k = 0; k < 60; k++) cycle(1, 0);
    end
    n_tests++; if (lives !== 2'd1 || state !== 2'd1) begin n_fail++; $display("FAIL lives_1 got lives %0d st %0d want 1 1", lives, state); end
    cycle(0, 1);
    n_tests++; if (state !== 2'd1 || lives !== 2'd1) begin n_fail++; $display("FAIL start_in_play got st %0d lives %0d want 1 1", state, lives); end
    set_slot(0, 1, 3'd6, 10'd320, 1); set_slot(1, 1, 3'd6, 10'd320, 0);
    cycle(1, 0);
    n_tests++; if (lives !== 2'd0 || state !== 2'd3 || hit_flash !== 1'b0) begin n_fail++; $display("FAIL over got lives %0d st %0d flash %b want 0 3 0", lives, state, hit_flash); end
    n_tests++; if (score_bcd !== 16'h0001 || bug_pulse !== 1'b1 || catch_pulse !== 1'b1) begin n_fail++; $display("FAIL over_score got %h bug %b catch %b want 0001 1 1", score_bcd, bug_pulse, catch_pulse); end
    cycle(1, 0);
    n_tests++; if (score_bcd !== 16'h0001 || state !== 2'd3 || catch_pulse !== 1'b0) begin n_fail++; $display("FAIL over_frozen got %h st %0d catch %b want 0001 3 0", score_bcd, state, catch_pulse); end
    cycle(0, 1);
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL over_idle got st %0d want 0", state); end
    cycle(0, 1);
    n_tests++; if (state !== 2'd1 || score_bcd !== 16'h0000 || lives !== 2'd3) begin n_fail++; $display("FAIL restart got st %0d score %h lives %0d want 1 0000 3", state, score_bcd, lives); end
  endtask

  task automatic test_non_eligible();
    do_reset();
    cycle(0, 1);
    farmer_x = 3'd4;
    set_slot(0, 1, 3'd3, 10'd320, 0);
    set_slot(1, 1, 3'd4, 10'd319, 0);
    set_slot(2, 1, 3'd4, 10'd321, 1);
    set_slot(3, 0, 3'd4, 10'd320, 1);
    cycle(1, 0);
    n_tests++; if (score_bcd !== 16'h0000 || lives !== 2'd3 || state !== 2'd1) begin n_fail++; $display("FAIL non_elig got %h lives %0d st %0d want 0000 3 1", score_bcd, lives, state); end
    n_tests++; if (catch_pulse !== 1'b0 || bug_pulse !== 1'b0) begin n_fail++; $display("FAIL non_elig_pulse got %b%b want 00", catch_pulse, bug_pulse); end
  endtask

  task automatic test_start_tick_idle();
    do_reset();
    farmer_x = 3'd0; set_slot(0, 1, 3'd0, 10'd320, 0);
    cycle(1, 1);
    n_tests++; if (state !== 2'd1 || score_bcd !== 16'h0000 || catch_pulse !== 1'b0) begin n_fail++; $display("FAIL start_tick got st %0d score %h catch %b want 1 0000 0", state, score_bcd, catch_pulse); end
  endtask

  task automatic test_reset_mid_hit();
    do_reset();
    cycle(0, 1);
    farmer_x = 3'd3;
    set_slot(0, 1, 3'd3, 10'd320, 1); set_slot(1, 1, 3'd3, 10'd320, 0);
    cycle(1, 0);
    cycle(1, 0);
    tick = 1;
    #2 rst = 1;
    #1;
    n_tests++; if (state !== 2'd0 || lives !== 2'd3 || score_bcd !== 16'h0000 || hit_flash !== 1'b0) begin n_fail++; $display("FAIL rst_async got st %0d lives %0d score %h flash %b want 0 3 0000 0", state, lives, score_bcd, hit_flash); end
    @(posedge clk); #1;
    rst = 0; tick = 0;
    model_reset();
    n_tests++; if (state !== 2'd0 || score_bcd !== 16'h0000 || catch_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_hold got st %0d score %h catch %b want 0 0000 0", state, score_bcd, catch_pulse); end
  endtask

  task automatic test_random();
    logic [9:0] ys [4];
    ys[0] = 10'd320; ys[1] = 10'd319; ys[2] = 10'd321; ys[3] = 10'd0;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      farmer_x = 3'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) begin
        logic [2:0] ln = ($urandom % 3 != 0) ? farmer_x : 3'($urandom_range(0, 7));
        logic [9:0] y = ($urandom % 2 == 0) ? 10'd320 : ys[$urandom_range(0, 3)];
        set_slot(i, 1'($urandom % 4 != 0), ln, y, 1'($urandom % 6 == 0));
      end
      cycle(1'($urandom % 2), 1'($urandom % 12 == 0));
      n_tests++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state @%0d got %0d want %0d", k, state, m_state); end
      n_tests++; if (score_bcd !== to_bcd(m_score)) begin n_fail++; $display("FAIL rnd_score @%0d got %h want %h", k, score_bcd, to_bcd(m_score)); end
      n_tests++; if (lives !== 2'(m_lives)) begin n_fail++; $display("FAIL rnd_lives @%0d got %0d want %0d", k, lives, m_lives); end
      n_tests++; if (hit_flash !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_flash @%0d got %b want %b", k, hit_flash, m_state == 2); end
      n_tests++; if (catch_pulse !== m_catch) begin n_fail++; $display("FAIL rnd_catch @%0d got %b want %b", k, catch_pulse, m_catch); end
      n_tests++; if (bug_pulse !== m_bug) begin n_fail++; $display("FAIL rnd_bug @%0d got %b want %b", k, bug_pulse, m_bug); end
    end
  endtask

  initial begin
    rst = 1; tick = 0; start = 0; farmer_x = '0; clear_slots();
    model_reset();
    #12;
    test_reset();
    test_first_catch();
    test_bcd_carry();
    test_bugs_hit();
    test_game_over();
    test_non_eligible();
    test_start_tick_idle();
    test_reset_mid_hit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/catch_scorer.md
CATCH_SCORER -- requirements
Module: catch_scorer

Interface
REQ-001 Parameter NUM_OBJ, 4, number of falling-object slots checked per frame tick.
REQ-002 Parameter CATCH_Y, 320, object top-row v-position at which the catch check fires (object bottom meets the farmer row at 400).
REQ-003 Parameter LIVES_INIT, 3, lives loaded on each new game.
REQ-004 Parameter HIT_TICKS, 60, length of the post-hit invincibility/flash window in frame ticks.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  reset: rst, asynchronous, active-high; clock clk.
REQ-007 tick  in  1  one-cycle pulse coinciding with each object position update.
REQ-008 start  in  1  one-cycle start/restart pulse from key decoding.
REQ-009 farmer_x  in  3  farmer lane 0..7.
REQ-010 obj_valid  in  NUM_OBJ  slot i currently shown.
REQ-011 obj_lane  in  3*NUM_OBJ  lane of slot i, bits [3i+2:3i].
REQ-012 obj_y  in  10*NUM_OBJ  top v-position of slot i, bits [10i+9:10i].
REQ-013 obj_is_bug  in  NUM_OBJ  1 = bug (harmful), 0 = vegetable (scores).
REQ-014 score_bcd  out  16  four BCD digits, digit 0 in [3:0].
REQ-015 lives  out  2  remaining lives.
REQ-016 state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3.
REQ-017 hit_flash  out  1  high throughout HIT state.
REQ-018 catch_pulse  out  1  one-cycle pulse when >=1 vegetable caught on a tick.
REQ-019 bug_pulse  out  1  one-cycle pulse when a life is lost.

Function
REQ-020 Evaluation SHALL occur only on cycles with tick=1 and state PLAY or HIT; all outputs SHALL update on the following clock edge (latency 1).
REQ-021 Slot i SHALL be eligible iff obj_valid[i]=1, obj_y_i==CATCH_Y and obj_lane_i==farmer_x, sampled on the tick cycle.
REQ-022 Score SHALL increase by the count of eligible vegetables (0..NUM_OBJ) per tick, BCD-correct, saturating at 9999.
REQ-023 Any eligible bug in PLAY SHALL decrement lives by exactly 1 regardless of bug count and enter HIT; in HIT, eligible bugs SHALL be ignored.
REQ-024 Eligible vegetables SHALL score in both PLAY and HIT, including the tick on which a life is lost.
REQ-025 If lives reaches 0, state SHALL go to OVER instead of HIT; hit_flash low, score frozen.
REQ-026 HIT SHALL last exactly HIT_TICKS ticks, then return to PLAY.
REQ-027 IDLE --start--> PLAY with score=0, lives=LIVES_INIT; OVER --start--> IDLE; start in PLAY/HIT SHALL be ignored.
REQ-028 Simultaneous tick and start in IDLE: start takes effect, the tick SHALL not be evaluated.
REQ-029 Non-eligible objects (wrong lane, invalid, y!=CATCH_Y) SHALL have no effect; obj_y values 0..479 wrap is handled upstream.
REQ-030 catch_pulse and bug_pulse SHALL be high for exactly one cycle after the evaluating tick, else low.

Reset
REQ-031 On rst: state=IDLE, score_bcd=0, lives=LIVES_INIT, hit counter=0, hit_flash=0, catch_pulse=0, bug_pulse=0.
REQ-032 rst asserted mid-HIT or mid-evaluation SHALL abort immediately; no pending increment survives.

Structure
REQ-033 State encoding, CATCH_Y default, LIVES_INIT default and BCD max (9999) SHALL live in the shared game package.
REQ-034 One sub-module bcd_add_sat SHALL add a small binary count (0..NUM_OBJ) to a 4-digit BCD value with saturation.
REQ-035 Eligibility SHALL be combinational per slot; score, lives, state and hit counter registered.

Verification
REQ-036 rst, start, tick with vegetable slot0 lane 2, y=320, farmer_x=2 -> score_bcd=0x0001, catch_pulse 1 cycle.
REQ-037 Score 0x0099 plus two eligible vegetables on one tick -> 0x0101; from 0x9998 plus two -> 0x9999.
REQ-038 Two eligible bugs same tick in PLAY -> lives 3->2, state HIT, bug_pulse once; bug on next tick -> lives stay 2; after 60 ticks -> PLAY.
REQ-039 lives=1, eligible bug plus eligible vegetable same tick -> lives 0, state OVER, score +1; further ticks ignored; start -> IDLE, start -> PLAY score 0 lives 3.
REQ-040 Object y=320 in lane 3 with farmer_x=4, and y=319 lane 4 -> no score or life change.
REQ-041 rst asserted during HIT -> IDLE, lives 3, score 0 on the next observed cycle.
